// File: rtl/flash_arbiter_pkg.sv
// Shared types and constants for the two-port flash arbiter.
//   state_t       : sequencer states (IDLE, WAIT, DONE)
//   FLASH_*_W     : flash engine address / data widths
//   PORT_FETCH/DATA : requester port indices (also the encoding of last_grant)
package flash_arb_pkg;

  localparam int FLASH_ADDR_W = 24;
  localparam int FLASH_DATA_W = 32;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/flash_arbiter_if.sv
// Requester-side request/response bundle for one arbiter port.
//   master : requester (drives req_valid/req_write/req_addr/req_wdata)
//   slave  : arbiter   (drives req_ready and the response pulse fields)
// The fetch port ties req_write/req_wdata to anything; the arbiter ignores them.
interface flash_arbiter_if;
  import flash_arb_pkg::*;

  logic                    req_valid;
  logic                    req_write;
  logic [FLASH_ADDR_W-1:0] req_addr;
  logic [FLASH_DATA_W-1:0] req_wdata;
  logic                    req_ready;
  logic                    resp_valid;
  logic [FLASH_DATA_W-1:0] resp_data;
  logic                    resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/flash_rr_pick2.sv
// Combinational two-way round-robin picker.
//   valid0/valid1 : request valids of port 0 / port 1
//   last_grant    : port index granted most recently
//   grant         : one-hot grant (bit N = port N)
//   any           : at least one port requesting
module flash_rr_pick2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       any
);

  // On a tie the port that did not win last time is chosen.
  assign grant[0] = valid0 & (~valid1 | last_grant);
  assign grant[1] = valid1 & (~valid0 | ~last_grant);
  assign any      = valid0 | valid1;

endmodule

// File: rtl/flash_arbiter.sv
// Arbiter/sequencer sharing the SPI flash engine between an instruction
// fetch port (req0, read-only) and a data port (req1, read/write).
// One word transaction at a time; flash_en is held until the engine pulses
// flash_ready or the timeout expires, then a one-cycle response is returned
// to the owning port.
//   clk, reset     : flash-domain clock, async active-high reset
//   req0, req1     : requester bundles (slave side)
//   flash_en/write/addr/data_in : registered engine controls
//   flash_data_out, flash_ready : engine read word and completion pulse
//   busy           : high whenever the sequencer is not idle
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2**20 - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  flash_arbiter_if.slave          req0,
  flash_arbiter_if.slave          req1,
  output logic                    flash_en,
  output logic                    flash_write,
  output logic [FLASH_ADDR_W-1:0] flash_addr,
  output logic [FLASH_DATA_W-1:0] flash_data_in,
  input  logic [FLASH_DATA_W-1:0] flash_data_out,
  input  logic                    flash_ready,
  output logic                    busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t                  state;
  logic                    owner;
  logic                    last_grant;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              grant;
  logic                    any_valid;
  logic                    finish;
  logic [FLASH_DATA_W-1:0] done_data;
  logic                    done_err;

  logic                    r0_valid, r1_valid, r0_err, r1_err;
  logic [FLASH_DATA_W-1:0] r0_data, r1_data;

  // Address low bits and the fetch port's write fields carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{req0.req_write, req0.req_wdata,
                         req0.req_addr[1:0], req1.req_addr[1:0]};

  flash_rr_pick2 u_pick (
    .valid0     (req0.req_valid),
    .valid1     (req1.req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (any_valid)
  );

  assign req0.req_ready = (state == IDLE) & grant[0];
  assign req1.req_ready = (state == IDLE) & grant[1];

  // Engine completion beats the timeout when both land on the same cycle.
  assign finish    = (state == WAIT) & (flash_ready | (cnt == CNT_LAST));
  assign done_err  = ~flash_ready;
  assign done_data = (flash_ready & ~flash_write) ? flash_data_out : '0;

  assign req0.resp_valid = r0_valid;
  assign req0.resp_data  = r0_data;
  assign req0.resp_err   = r0_err;
  assign req1.resp_valid = r1_valid;
  assign req1.resp_data  = r1_data;
  assign req1.resp_err   = r1_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= PORT_FETCH;
      last_grant    <= PORT_DATA;
      cnt           <= '0;
      flash_en      <= 1'b0;
      flash_write   <= 1'b0;
      flash_addr    <= '0;
      flash_data_in <= '0;
      busy          <= 1'b0;
      r0_valid      <= 1'b0;
      r0_data       <= '0;
      r0_err        <= 1'b0;
      r1_valid      <= 1'b0;
      r1_data       <= '0;
      r1_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // In IDLE any valid request is accepted in the same cycle.
          if (any_valid) begin
            owner         <= grant[1];
            last_grant    <= grant[1];
            flash_addr    <= grant[1] ? {req1.req_addr[FLASH_ADDR_W-1:2], 2'b00}
                                      : {req0.req_addr[FLASH_ADDR_W-1:2], 2'b00};
            flash_write   <= grant[1] & req1.req_write;
            flash_data_in <= grant[1] ? req1.req_wdata : '0;
            cnt           <= '0;
            flash_en      <= 1'b1;
            busy          <= 1'b1;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (finish) begin
            flash_en <= 1'b0;
            state    <= DONE;
            if (owner == PORT_DATA) begin
              r1_valid <= 1'b1;
              r1_data  <= done_data;
              r1_err   <= done_err;
            end else begin
              r0_valid <= 1'b1;
              r0_data  <= done_data;
              r0_err   <= done_err;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          r0_valid <= 1'b0;
          r0_data  <= '0;
          r0_err   <= 1'b0;
          r1_valid <= 1'b0;
          r1_data  <= '0;
          r1_err   <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: directed vector table, hand-written
// corner sequences (stray ready, reset inside WAIT) and randomized traffic
// checked against a transaction-level round-robin/timeout model.
module tb_flash_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flash_en, flash_write, flash_ready, busy;
  logic [23:0] flash_addr;
  logic [31:0] flash_data_in, flash_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  flash_arbiter_if if0 ();
  flash_arbiter_if if1 ();

  flash_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (if0),
    .req1           (if1),
    .flash_en       (flash_en),
    .flash_write    (flash_write),
    .flash_addr     (flash_addr),
    .flash_data_in  (flash_data_in),
    .flash_data_out (flash_data_out),
    .flash_ready    (flash_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // flash_en must stay low for at least two cycles between transactions.
  int low_run = 0;
  bit seen_txn = 0;
  bit prev_en = 0;
  always @(negedge clk) begin
    if (reset) begin
      seen_txn = 0;
      prev_en  = 0;
      low_run  = 0;
    end else begin
      if (flash_en) begin
        if (!prev_en && seen_txn) check("en_gap", 32'(low_run >= 2), 32'd1);
        low_run  = 0;
        seen_txn = 1;
      end else begin
        low_run++;
      end
      prev_en = flash_en;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready0"}, if0.req_ready, 0);
    check({tag, "_ready1"}, if1.req_ready, 0);
    check({tag, "_rv0"}, if0.resp_valid, 0);
    check({tag, "_rv1"}, if1.resp_valid, 0);
    check({tag, "_rd0"}, if0.resp_data, 0);
    check({tag, "_rd1"}, if1.resp_data, 0);
    check({tag, "_re0"}, if0.resp_err, 0);
    check({tag, "_re1"}, if1.resp_err, 0);
    check({tag, "_en"}, flash_en, 0);
    check({tag, "_wr"}, flash_write, 0);
    check({tag, "_addr"}, flash_addr, 0);
    check({tag, "_din"}, flash_data_in, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // delay = WAIT cycle (1-based) in which the engine pulses ready; 0 = never.
  task automatic do_txn(input bit v0, input bit v1, input bit w1,
                        input logic [23:0] a0, input logic [23:0] a1,
                        input logic [31:0] wd, input int delay, input logic [31:0] edata,
                        input int exp_port, input logic [31:0] exp_data, input bit exp_err);
    int c;
    bit done;
    int exp_len;
    logic [23:0] ea;
    bit ew;
    ea = ((exp_port == 0) ? a0 : a1) & 24'hFFFFFC;
    ew = (exp_port == 1) && w1;
    exp_len = (delay >= 1 && delay <= TMO) ? delay : TMO;

    @(negedge clk);
    if0.req_valid = v0;  if0.req_write = 1'($urandom); if0.req_addr = a0;
    if0.req_wdata = $urandom;
    if1.req_valid = v1;  if1.req_write = w1; if1.req_addr = a1; if1.req_wdata = wd;
    #1;
    check("ready0", if0.req_ready, 32'(exp_port == 0));
    check("ready1", if1.req_ready, 32'(exp_port == 1));
    check("idle_busy", busy, 0);

    @(posedge clk); #1;
    if0.req_valid = 0; if1.req_valid = 0;
    if0.req_addr = 24'($urandom); if1.req_addr = 24'($urandom);
    if1.req_wdata = $urandom; if1.req_write = 1'($urandom);
    c = 1;
    done = 0;
    while (!done) begin
      check("en", flash_en, 1);
      check("addr", flash_addr, 32'(ea));
      check("write", flash_write, 32'(ew));
      if (ew) check("wdata", flash_data_in, wd);
      check("busy", busy, 1);
      if (c == delay) begin
        flash_ready = 1; flash_data_out = edata;
      end else begin
        flash_ready = 0; flash_data_out = $urandom;
      end
      @(posedge clk); #1;
      flash_ready = 0;
      if (!flash_en) done = 1;
      else if (c >= TMO + 4) begin
        n_checks++; n_fail++;
        $display("FAIL en_bound: flash_en still high after %0d cycles, required %0d", c, exp_len);
        done = 1;
      end else c++;
    end
    check("en_len", c, exp_len);
    check("rv0", if0.resp_valid, 32'(exp_port == 0));
    check("rv1", if1.resp_valid, 32'(exp_port == 1));
    check("rdata", (exp_port == 0) ? if0.resp_data : if1.resp_data, exp_data);
    check("rerr", (exp_port == 0) ? if0.resp_err : if1.resp_err, 32'(exp_err));
    check("other_data", (exp_port == 0) ? if1.resp_data : if0.resp_data, 0);
    check("other_err", (exp_port == 0) ? if1.resp_err : if0.resp_err, 0);
    @(posedge clk); #1;
    check("rv0_end", if0.resp_valid, 0);
    check("rv1_end", if1.resp_valid, 0);
    check("busy_end", busy, 0);
  endtask

  typedef struct {
    bit          v0, v1, w1;
    logic [23:0] a0, a1;
    logic [31:0] wd;
    int          delay;
    logic [31:0] edata;
    int          exp_port;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  bit model_last;

  initial begin
    if0.req_valid = 0; if0.req_write = 0; if0.req_addr = 0; if0.req_wdata = 0;
    if1.req_valid = 0; if1.req_write = 0; if1.req_addr = 0; if1.req_wdata = 0;
    flash_ready = 0; flash_data_out = 0;

    vecs[0] = '{1, 1, 0, 24'h000103, 24'h000020, 32'h0,        5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[1] = '{1, 1, 1, 24'h000010, 24'h000200, 32'hCAFEF00D, 3,  32'h12345678, 1, 32'h0,        0};
    vecs[2] = '{1, 1, 0, 24'h000044, 24'h000088, 32'h0,        1,  32'h11111111, 0, 32'h11111111, 0};
    vecs[3] = '{0, 1, 0, 24'h000000, 24'h000207, 32'h0,        0,  32'h0,        1, 32'h0,        1};
    vecs[4] = '{0, 1, 0, 24'h000000, 24'h00020B, 32'h0,        2,  32'h44444444, 1, 32'h44444444, 0};
    vecs[5] = '{1, 0, 0, 24'hFFFFFF, 24'h000000, 32'h0,        16, 32'h55555555, 0, 32'h55555555, 0};
    vecs[6] = '{1, 1, 1, 24'h000100, 24'hABCDEF, 32'h01020304, 17, 32'h66666666, 1, 32'h0,        1};
    vecs[7] = '{1, 1, 1, 24'h123456, 24'h000003, 32'h0A0B0C0D, 2,  32'h77777777, 0, 32'h77777777, 0};

    #2 reset = 1;
    #2 check_reset_vals("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;

    foreach (vecs[i])
      do_txn(vecs[i].v0, vecs[i].v1, vecs[i].w1, vecs[i].a0, vecs[i].a1, vecs[i].wd,
             vecs[i].delay, vecs[i].edata, vecs[i].exp_port, vecs[i].exp_data, vecs[i].exp_err);

    // Stray engine ready while idle must not produce a response.
    @(negedge clk);
    flash_ready = 1; flash_data_out = 32'hBADBAD00;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_rv0", if0.resp_valid, 0);
      check("stray_rv1", if1.resp_valid, 0);
      check("stray_en", flash_en, 0);
      check("stray_busy", busy, 0);
    end
    flash_ready = 0;

    // Reset during the third WAIT cycle aborts the transaction silently.
    @(negedge clk);
    if1.req_valid = 1; if1.req_write = 1; if1.req_addr = 24'h000300; if1.req_wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    if1.req_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    check("wait3_en", flash_en, 1);
    #2 reset = 1;
    #1 check_reset_vals("rstwait");
    @(negedge clk) reset = 0;
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_rv0", if0.resp_valid, 0);
      check("abort_rv1", if1.resp_valid, 0);
      check("abort_en", flash_en, 0);
    end

    // Randomized traffic against a transaction-level model.
    model_last = 1;
    for (int k = 0; k < 40; k++) begin
      bit v0, v1, w1, is_wr, tmo;
      logic [23:0] a0, a1;
      logic [31:0] wd, ed, exp_d;
      int dly, port;
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1;
      w1 = 1'($urandom);
      a0 = 24'($urandom); a1 = 24'($urandom);
      wd = $urandom; ed = $urandom;
      dly = $urandom_range(0, 18);
      if (v0 && v1) port = model_last ? 0 : 1;
      else          port = v0 ? 0 : 1;
      model_last = (port == 1);
      is_wr = (port == 1) && w1;
      tmo   = !(dly >= 1 && dly <= TMO);
      exp_d = (is_wr || tmo) ? 32'h0 : ed;
      do_txn(v0, v1, w1, a0, a1, wd, dly, ed, port, exp_d, tmo);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
